// File: rtl/mas_mul_pkg.sv
// Shared widths, state encoding and counter sizing for the shift-add multiplier.
package mas_mul_pkg;
  localparam int OP_W_DEF  = 32;
  localparam int RES_W_DEF = 2 * OP_W_DEF;
  localparam int CNT_W_DEF = $clog2(OP_W_DEF) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One extra bit so the step counter can reach OP_W without wrapping.
  function automatic int cnt_width(input int op_w);
    return $clog2(op_w) + 1;
  endfunction
endpackage

// File: rtl/mas_mul_step.sv
// One radix-2 shift-add step: conditionally adds mcand<<cnt into acc, shifts mplier right.
// Purely combinational; the caller owns all state.
module mas_mul_step
  import mas_mul_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int RES_W = 2 * OP_W,
  parameter int CNT_W = cnt_width(OP_W)
) (
  input  logic [RES_W-1:0] i_acc,
  input  logic [OP_W-1:0]  i_mcand,
  input  logic [OP_W-1:0]  i_mplier,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [RES_W-1:0] o_acc,
  output logic [OP_W-1:0]  o_mplier
);
  logic [RES_W-1:0] w_mcand_ext;
  logic [RES_W-1:0] w_addend;

  assign w_mcand_ext = {{(RES_W-OP_W){1'b0}}, i_mcand};
  assign w_addend    = w_mcand_ext << i_cnt;
  assign o_acc       = i_mplier[0] ? (i_acc + w_addend) : i_acc;
  assign o_mplier    = i_mplier >> 1;
endmodule

// File: rtl/mas_mul_core.sv
// Sequential unsigned multiplier: accepts in IDLE, runs OP_W shift-add steps, holds result in DONE.
// Latency OP_W cycles; result held until out_ready, no new operands accepted until then.
module mas_mul_core
  import mas_mul_pkg::*;
#(
  parameter  int OP_W  = OP_W_DEF,
  localparam int RES_W = 2 * OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in1,
  input  logic [OP_W-1:0]  in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] res
);
  localparam int CNT_W = cnt_width(OP_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OP_W - 1);

  state_t           r_state;
  logic [OP_W-1:0]  r_mcand;
  logic [OP_W-1:0]  r_mplier;
  logic [RES_W-1:0] r_acc;
  logic [RES_W-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [RES_W-1:0] w_acc_nxt;
  logic [OP_W-1:0]  w_mplier_nxt;

  mas_mul_step #(
    .OP_W  (OP_W),
    .RES_W (RES_W),
    .CNT_W (CNT_W)
  ) u_step (
    .i_acc    (r_acc),
    .i_mcand  (r_mcand),
    .i_mplier (r_mplier),
    .i_cnt    (r_cnt),
    .o_acc    (w_acc_nxt),
    .o_mplier (w_mplier_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mcand    <= in1;
            r_mplier   <= in2;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= ST_CALC;
            r_in_ready <= 1'b0;
          end
        end
        ST_CALC: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= w_mplier_nxt;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Fixed step count: no early exit even when mplier runs out of ones.
          if (r_cnt == LAST_CNT) begin
            r_res       <= w_acc_nxt;
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign res       = r_res;
endmodule

// File: tb/tb_mas_mul_core.sv
// Self-checking bench for mas_mul_core: directed boundary cases plus randomized regression
// against a 64-bit arithmetic reference model.
module tb_mas_mul_core;
  localparam int OP_W  = 32;
  localparam int RES_W = 64;
  localparam int LAT   = OP_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in1;
  logic [OP_W-1:0]  in2;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] res;

  int n_checks = 0;
  int n_pass   = 0;

  mas_mul_core #(.OP_W(OP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] ref_mul(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    logic [RES_W-1:0] wa;
    logic [RES_W-1:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  // Presents one operand pair for a single edge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    in_valid = 1'b1;
    in1      = a;
    in2      = b;
    @(negedge clk);
    in_valid = 1'b0;
    in1      = $urandom;
    in2      = $urandom;
  endtask

  // Counts edges after the accept edge until out_valid is seen; gives up after 200.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_op(input int stall);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in1 = 32'd11;
    in2 = 32'd13;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++;
    if (res !== 64'd0) $display("FAIL reset_res: got %h expected 0", res);
    else n_pass++;
  endtask

  task automatic test_basic;
    logic [OP_W-1:0] va [3];
    logic [OP_W-1:0] vb [3];
    logic [RES_W-1:0] exp_res [3];
    int lat;
    va[0] = 32'd3;          vb[0] = 32'd5;          exp_res[0] = 64'd15;
    va[1] = 32'd0;          vb[1] = 32'hFFFF_FFFF;  exp_res[1] = 64'd0;
    va[2] = 32'hFFFF_FFFF;  vb[2] = 32'hFFFF_FFFF;  exp_res[2] = 64'hFFFF_FFFE_0000_0001;
    for (int k = 0; k < 3; k++) begin
      start_op(va[k], vb[k]);
      wait_done(lat);
      n_checks++;
      if (lat != LAT) $display("FAIL basic_latency[%0d]: got %0d expected %0d", k, lat, LAT);
      else n_pass++;
      n_checks++;
      if (res !== exp_res[k]) $display("FAIL basic_res[%0d]: got %h expected %h", k, res, exp_res[k]);
      else n_pass++;
      release_op(0);
    end
  endtask

  task automatic test_backpressure;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [RES_W-1:0] held;
    int lat;
    int bad;
    a = $urandom;
    b = $urandom;
    start_op(a, b);
    wait_done(lat);
    held = res;
    n_checks++;
    if (held !== ref_mul(a, b)) $display("FAIL bp_res: got %h expected %h", held, ref_mul(a, b));
    else n_pass++;
    bad = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || res !== held) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL bp_stable: %0d unstable cycles, required 0", bad);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_busy;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    int lat;
    int busy_bad;
    int extra;
    a = $urandom;
    b = $urandom;
    in_valid  = 1'b1;
    in1       = a;
    in2       = b;
    out_ready = 1'b1;
    @(negedge clk);
    lat = 0;
    busy_bad = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) busy_bad++;
      in1 = $urandom;
      in2 = $urandom;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (busy_bad != 0) $display("FAIL busy_in_ready: %0d cycles with in_ready high, required 0", busy_bad);
    else n_pass++;
    n_checks++;
    if (lat != LAT) $display("FAIL busy_latency: got %0d expected %0d", lat, LAT);
    else n_pass++;
    n_checks++;
    if (res !== ref_mul(a, b)) $display("FAIL busy_res: got %h expected %h", res, ref_mul(a, b));
    else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL busy_return: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else n_pass++;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL busy_single_result: %0d extra valid cycles, required 0", extra);
    else n_pass++;
  endtask

  task automatic test_mid_reset;
    int seen;
    int lat;
    start_op(32'hDEAD_BEEF, 32'h1234_5678);
    for (int i = 1; i < 10; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midrst_state: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL midrst_no_result: %0d valid cycles, required 0", seen);
    else n_pass++;
    start_op(32'd7, 32'd9);
    wait_done(lat);
    n_checks++;
    if (lat != LAT || res !== 64'd63)
      $display("FAIL midrst_next: lat=%0d res=%h expected %0d/%h", lat, res, LAT, 64'd63);
    else n_pass++;
    release_op(0);
  endtask

  task automatic test_random;
    logic [OP_W-1:0] qa [$];
    logic [OP_W-1:0] qb [$];
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [RES_W-1:0] exp_res;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 7))
        0: a = 32'd0;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'd1 << $urandom_range(0, 31);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1 << $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      qa.push_back(a);
      qb.push_back(b);
      out_ready = $urandom_range(0, 1);
      start_op(a, b);
      wait_done(lat);
      exp_res = ref_mul(qa.pop_front(), qb.pop_front());
      n_checks++;
      if (lat != LAT || res !== exp_res)
        $display("FAIL rand[%0d]: lat=%0d res=%h expected %0d/%h", n, lat, res, LAT, exp_res);
      else n_pass++;
      release_op($urandom_range(0, 3));
      if (lat >= 200) break;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    out_ready = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_busy;
    test_mid_reset;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
